// File: rtl/pre_sram_ctrl_if.sv
// Stream interface for pre_sram_ctrl: the upstream write stream and the
// downstream read stream, each with a valid/ready handshake.
// The slave modport is the controller's view. The master modport is the
// view of whatever sits around it.
interface pre_sram_ctrl_if #(
  parameter int data_width = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pre_sram_ctrl.sv
// pre_sram_ctrl: buffers one frame of words from a write stream into an
// external asynchronous SRAM. It then replays the frame in order on a read
// stream. Each read takes three cycles: ISSUE, CAP and HOLD.
// Optional feature macro PRE_SRAM_PINGPONG_EN alternates the two SRAM banks
// on successive frames. Without it, only bank 1 is used and the bank 2 pins
// stay idle.
module pre_sram_ctrl #(
  parameter int data_width = 16,
  parameter int addr_width = 10,
  parameter int frame_len  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  pre_sram_ctrl_if.slave        s,
  output logic                  cs1,
  output logic                  cs2,
  output logic                  oe1,
  output logic                  oe2,
  output logic                  we1,
  output logic                  we2,
  output logic [addr_width-1:0] addr,
  inout  wire  [data_width-1:0] data1,
  inout  wire  [data_width-1:0] data2,
  output logic                  frame_done,
  output logic                  bank_sel
);

  localparam logic [addr_width-1:0] LAST = addr_width'(frame_len - 1);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_CAP   = 2'd2,
    RD_HOLD  = 2'd3
  } state_t;

  state_t                state_q;
  logic [addr_width-1:0] k_q;
  logic [data_width-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  frame_done_q;
  logic                  bank_q;
  logic                  wr_fire;
  logic                  rd_act;

  // The write strobes follow in_valid in the same cycle, so they are
  // combinational. Everything is gated off while reset is high.
  assign s.in_ready = (state_q == FILL) && !rst;
  assign wr_fire    = s.in_ready && s.in_valid;
  assign rd_act     = !rst && ((state_q == RD_ISSUE) || (state_q == RD_CAP));

  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign frame_done  = frame_done_q;
  assign bank_sel    = bank_q;
  assign addr        = k_q;

  assign cs1   = !bank_q && (wr_fire || rd_act);
  assign oe1   = !bank_q && rd_act;
  assign we1   = !bank_q && wr_fire;
  assign data1 = we1 ? s.in_data : {data_width{1'bz}};

`ifdef PRE_SRAM_PINGPONG_EN
  assign cs2   = bank_q && (wr_fire || rd_act);
  assign oe2   = bank_q && rd_act;
  assign we2   = bank_q && wr_fire;
  assign data2 = we2 ? s.in_data : {data_width{1'bz}};
`else
  assign bank_q = 1'b0;
  assign cs2    = 1'b0;
  assign oe2    = 1'b0;
  assign we2    = 1'b0;
  assign data2  = {data_width{1'bz}};
`endif

  // Frame sequencer: fill the SRAM, then read back one word per three cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      k_q          <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef PRE_SRAM_PINGPONG_EN
      bank_q       <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        FILL: begin
          if (s.in_valid) begin
            if (k_q == LAST) begin
              k_q     <= '0;
              state_q <= RD_ISSUE;
            end else begin
              k_q <= k_q + 1'b1;
            end
          end
        end
        RD_ISSUE: begin
          state_q <= RD_CAP;
        end
        RD_CAP: begin
          out_data_q  <= bank_q ? data2 : data1;
          out_valid_q <= 1'b1;
          state_q     <= RD_HOLD;
        end
        RD_HOLD: begin
          if (s.out_ready) begin
            out_valid_q <= 1'b0;
            if (k_q == LAST) begin
              k_q          <= '0;
              frame_done_q <= 1'b1;
              state_q      <= FILL;
`ifdef PRE_SRAM_PINGPONG_EN
              bank_q       <= ~bank_q;
`endif
            end else begin
              k_q     <= k_q + 1'b1;
              state_q <= RD_ISSUE;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_pre_sram_ctrl.sv
// Directed testbench for pre_sram_ctrl with frame_len=4 and an SRAM model
// attached to both bank buses.
module tb_pre_sram_ctrl;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int FL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cs1, cs2, oe1, oe2, we1, we2;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data1;
  wire  [DW-1:0] data2;
  logic          frame_done;
  logic          bank_sel;

  pre_sram_ctrl_if #(.data_width(DW)) bus_if ();

  pre_sram_ctrl #(
    .data_width(DW),
    .addr_width(AW),
    .frame_len (FL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (bus_if),
    .cs1       (cs1),
    .cs2       (cs2),
    .oe1       (oe1),
    .oe2       (oe2),
    .we1       (we1),
    .we2       (we2),
    .addr      (addr),
    .data1     (data1),
    .data2     (data2),
    .frame_done(frame_done),
    .bank_sel  (bank_sel)
  );

  // Asynchronous SRAM model. Writes are taken at the clock edge, and reads
  // drive the bus while cs&oe&!we.
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem2 [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (cs1 && we1) mem1[addr] <= data1;
    if (cs2 && we2) mem2[addr] <= data2;
  end
  assign data1 = (cs1 && oe1 && !we1) ? mem1[addr] : {DW{1'bz}};
  assign data2 = (cs2 && oe2 && !we2) ? mem2[addr] : {DW{1'bz}};

  int   total = 0;
  int   bad = 0;
  int   fd_cnt = 0;
  logic exp_bank = 1'b0;

  // Per-cycle bus sanity checks and the frame_done counter.
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (!rst) begin
      total++;
      if ((cs1 && cs2) || (we1 && oe1) || (we2 && oe2) ||
          (bus_if.in_ready && bus_if.out_valid)) begin
        bad++;
        $display("FAIL bus_excl cs1=%0b cs2=%0b we1=%0b oe1=%0b we2=%0b oe2=%0b in_ready=%0b out_valid=%0b (required: exclusive)",
                 cs1, cs2, we1, oe1, we2, oe2, bus_if.in_ready, bus_if.out_valid);
      end
`ifndef PRE_SRAM_PINGPONG_EN
      total++;
      if ({cs2, oe2, we2} !== 3'b000) begin
        bad++;
        $display("FAIL bank2_idle got=%b want=000", {cs2, oe2, we2});
      end
`endif
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus_if.in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_in_ready got=%b want=0", bus_if.in_ready);
    end
    total++;
    if ({bus_if.out_valid, frame_done, bank_sel} !== 3'b000) begin
      bad++; $display("FAIL rst_flags got=%b want=000", {bus_if.out_valid, frame_done, bank_sel});
    end
    total++;
    if (addr !== '0 || bus_if.out_data !== '0) begin
      bad++; $display("FAIL rst_addr_data addr=%0d out_data=%h want 0,0", addr, bus_if.out_data);
    end
    total++;
    if ({cs1, oe1, we1, cs2, oe2, we2} !== 6'b000000) begin
      bad++; $display("FAIL rst_strobes got=%b want=000000", {cs1, oe1, we1, cs2, oe2, we2});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_bank = 1'b0;
    @(negedge clk);
    total++;
    if (bus_if.in_ready !== 1'b1) begin
      bad++; $display("FAIL fill_in_ready got=%b want=1", bus_if.in_ready);
    end
    @(posedge clk); #1;
  endtask

  // Entered at posedge+1 and left at posedge+1.
  task automatic write_word(input logic [DW-1:0] d, input int gap, input int idx);
    logic [5:0] exp_vec;
    exp_vec = exp_bank ? 6'b000101 : 6'b101000;
    repeat (gap) begin
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({cs1, oe1, we1, cs2, oe2, we2} !== 6'b000000 || addr !== AW'(idx)) begin
        bad++; $display("FAIL idle_gap strobes=%b addr=%0d want 000000 addr=%0d",
                        {cs1, oe1, we1, cs2, oe2, we2}, addr, idx);
      end
      @(posedge clk); #1;
    end
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    @(negedge clk);
    total++;
    if ({cs1, oe1, we1, cs2, oe2, we2} !== exp_vec) begin
      bad++; $display("FAIL wr_strobes got=%b want=%b", {cs1, oe1, we1, cs2, oe2, we2}, exp_vec);
    end
    total++;
    if (addr !== AW'(idx)) begin
      bad++; $display("FAIL wr_addr got=%0d want=%0d", addr, idx);
    end
    total++;
    if ((exp_bank ? data2 : data1) !== d) begin
      bad++; $display("FAIL wr_bus got=%h want=%h", (exp_bank ? data2 : data1), d);
    end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic read_word(input logic [DW-1:0] exp, input int stall);
    int         n;
    logic [5:0] rd_vec;
    rd_vec = exp_bank ? 6'b000110 : 6'b110000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n <= 2) begin
        total++;
        if ({cs1, oe1, we1, cs2, oe2, we2} !== rd_vec || bus_if.in_ready !== 1'b0) begin
          bad++; $display("FAIL rd_strobes got=%b in_ready=%b want=%b in_ready=0",
                          {cs1, oe1, we1, cs2, oe2, we2}, bus_if.in_ready, rd_vec);
        end
      end
    end while (!bus_if.out_valid && n < 20);
    total++;
    if (n !== 3) begin
      bad++; $display("FAIL rd_latency got=%0d cycles want=3", n);
    end
    total++;
    if (bus_if.out_data !== exp) begin
      bad++; $display("FAIL rd_data got=%h want=%h", bus_if.out_data, exp);
    end
    repeat (stall) begin
      @(negedge clk);
      total++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== exp) begin
        bad++; $display("FAIL rd_stall out_valid=%b out_data=%h want 1,%h",
                        bus_if.out_valid, bus_if.out_data, exp);
      end
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
  endtask

  // Fill one frame with base+i*step, honouring the per-word input gaps
  // (4 bits each in gaps), then read it back with the given stall per word.
  task automatic run_frame(input logic [DW-1:0] base, input logic [DW-1:0] step,
                           input logic [15:0] gaps, input int stall);
    int fd0;
    fd0 = fd_cnt;
    total++;
    if (bank_sel !== exp_bank) begin
      bad++; $display("FAIL bank_sel_start got=%b want=%b", bank_sel, exp_bank);
    end
    for (int i = 0; i < FL; i++)
      write_word(base + DW'(i) * step, int'(gaps[4*i +: 4]), i);
    for (int i = 0; i < FL; i++)
      read_word(base + DW'(i) * step, stall);
`ifdef PRE_SRAM_PINGPONG_EN
    exp_bank = ~exp_bank;
`endif
    @(negedge clk);
    total++;
    if (frame_done !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1) begin
      bad++; $display("FAIL frame_end frame_done=%b out_valid=%b in_ready=%b want 1,0,1",
                      frame_done, bus_if.out_valid, bus_if.in_ready);
    end
    total++;
    if (bank_sel !== exp_bank || addr !== '0) begin
      bad++; $display("FAIL frame_end_bank bank_sel=%b addr=%0d want %b,0", bank_sel, addr, exp_bank);
    end
    @(negedge clk);
    total++;
    if (frame_done !== 1'b0 || fd_cnt - fd0 !== 1) begin
      bad++; $display("FAIL frame_done_pulse level=%b pulses=%0d want 0,1", frame_done, fd_cnt - fd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    run_frame(16'h1111, 16'h1111, 16'h0000, 0);
  endtask

  task automatic test_gaps_stall();
    run_frame(16'h5A00, 16'h0101, 16'h1302, 5);
  endtask

  task automatic test_mid_reset();
    int fd0;
    fd0 = fd_cnt;
    write_word(16'hC0DE, 0, 0);
    write_word(16'hBEEF, 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_bank = 1'b0;
    @(negedge clk);
    total++;
    if (addr !== '0 || bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bank_sel !== 1'b0) begin
      bad++; $display("FAIL mid_rst addr=%0d in_ready=%b out_valid=%b bank_sel=%b want 0,1,0,0",
                      addr, bus_if.in_ready, bus_if.out_valid, bank_sel);
    end
    total++;
    if (fd_cnt !== fd0) begin
      bad++; $display("FAIL mid_rst_no_done pulses=%0d want=0", fd_cnt - fd0);
    end
    @(posedge clk); #1;
    run_frame(16'h0F01, 16'h1010, 16'h0000, 1);
  endtask

  task automatic test_pingpong();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_bank = 1'b0;
    @(posedge clk); #1;
    run_frame(16'hA000, 16'h0001, 16'h0000, 0);
    run_frame(16'hB000, 16'h0001, 16'h0000, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = '0;
    bus_if.out_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_gaps_stall();
    test_mid_reset();
    test_pingpong();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
